// File: rtl/latch_wr_seq.sv
// Write sequencer for a transparent D-latch bank: registered data/enable with
// programmable setup, pulse and hold windows around a glitch-free enable.
module latch_wr_seq #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  output logic [WIDTH-1:0] lat_in,
  output logic             lat_ena,
  output logic             busy,
  output logic             done
);

  generate
    if (WIDTH < 1 ||
        SETUP_CYC < 1 || SETUP_CYC > 255 ||
        PULSE_CYC < 1 || PULSE_CYC > 255 ||
        HOLD_CYC  < 1 || HOLD_CYC  > 255) begin : g_bad_param
      $error("latch_wr_seq: window lengths must be 1..255 and WIDTH >= 1");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  logic [1:0] state;
  logic [7:0] cnt;

  // Every output is a flop so the latch enable can never glitch on input activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      lat_in    <= '0;
      lat_ena   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_in    <= req_data;
            cnt       <= SETUP_LD;
            state     <= SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state   <= PULSE;
            lat_ena <= 1'b1;
            cnt     <= PULSE_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            state   <= HOLD;
            lat_ena <= 1'b0;
            cnt     <= HOLD_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          // ready rises with done so a back-to-back request lands in the done cycle
          if (cnt == 8'd0) begin
            state     <= IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
